// File: rtl/wvb_rd_arb_pkg.sv
// Shared types and default constants for the waveform-buffer read arbiter.
package wvb_rd_arb_pkg;

    localparam int C_N_CHAN    = 24;
    localparam int C_SEL_WIDTH = 5;
    localparam int C_TMO_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/wvb_rd_arb_if.sv
// Request/grant bundle between the waveform buffers, the arbiter and the readout engine.
interface wvb_rd_arb_if
    import wvb_rd_arb_pkg::*;
#(
    parameter int P_N_CHAN    = C_N_CHAN,
    parameter int P_SEL_WIDTH = C_SEL_WIDTH,
    parameter int P_TMO_WIDTH = C_TMO_WIDTH
);
    logic [P_N_CHAN-1:0]    hdr_rdy;
    logic [P_N_CHAN-1:0]    chan_en;
    logic                   pause;
    logic                   rd_done;
    logic [P_TMO_WIDTH-1:0] tmo_max;

    logic [P_N_CHAN-1:0]    grant;
    logic [P_SEL_WIDTH-1:0] chan_sel;
    logic                   rd_start;
    logic                   busy;
    logic                   tmo_err;
    logic [31:0]            n_evts;

    modport master (
        input  hdr_rdy, chan_en, pause, rd_done, tmo_max,
        output grant, chan_sel, rd_start, busy, tmo_err, n_evts
    );

    modport slave (
        output hdr_rdy, chan_en, pause, rd_done, tmo_max,
        input  grant, chan_sel, rd_start, busy, tmo_err, n_evts
    );

endinterface

// File: rtl/wvb_rd_arb_rr_sel.sv
// Combinational round-robin picker: first set request after index 'last', wrapping at N-1.
module rr_sel #(
    parameter int N     = 24,
    parameter int SEL_W = 5
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned pos;
        logic [SEL_W-1:0] cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = 0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos  = (32'(last) + 32'd1 + i) % N;
            cand = pos[SEL_W-1:0];
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wvb_rd_arb.sv
// Round-robin read arbiter for the waveform-buffer header FIFOs.
// Optional readout watchdog enabled by defining WVB_RD_ARB_TIMEOUT_EN.
module wvb_rd_arb
    import wvb_rd_arb_pkg::*;
#(
    parameter int P_N_CHAN    = C_N_CHAN,
    parameter int P_SEL_WIDTH = C_SEL_WIDTH,
    parameter int P_TMO_WIDTH = C_TMO_WIDTH
) (
    input logic          clk,
    input logic          i_rst,
    wvb_rd_arb_if.master bus
);

    state_t                 state_q, state_d;
    logic [P_N_CHAN-1:0]    grant_q, grant_d;
    logic [P_SEL_WIDTH-1:0] sel_q, sel_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [P_SEL_WIDTH-1:0] last_q, last_d;
    logic [31:0]            evts_q, evts_d;

    logic [P_N_CHAN-1:0]    elig;
    logic [P_N_CHAN-1:0]    pick_oh;
    logic [P_SEL_WIDTH-1:0] pick_idx;
    logic                   pick_valid;

    assign elig = bus.hdr_rdy & bus.chan_en;

    rr_sel #(
        .N     (P_N_CHAN),
        .SEL_W (P_SEL_WIDTH)
    ) u_rr_sel (
        .req    (elig),
        .last   (last_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

`ifdef WVB_RD_ARB_TIMEOUT_EN
    logic [P_TMO_WIDTH-1:0] wdog_q, wdog_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   expire;

    // wdog_q is 0 on the first S_WAIT cycle, so expiry lands on cycle tmo_max of S_WAIT
    assign expire = (bus.tmo_max != '0) && (wdog_q >= bus.tmo_max - P_TMO_WIDTH'(1));
`endif

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        sel_d   = '0;
        start_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = last_q;
        evts_d  = evts_q;
`ifdef WVB_RD_ARB_TIMEOUT_EN
        wdog_d    = '0;
        tmo_err_d = tmo_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!bus.pause && pick_valid) begin
                    state_d = S_START;
                    grant_d = pick_oh;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                grant_d = grant_q;
                sel_d   = sel_q;
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                grant_d = grant_q;
                sel_d   = sel_q;
                busy_d  = 1'b1;
`ifdef WVB_RD_ARB_TIMEOUT_EN
                wdog_d  = wdog_q + P_TMO_WIDTH'(1);
`endif
                if (bus.rd_done) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = sel_q;
                    evts_d  = evts_q + 32'd1;
`ifdef WVB_RD_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
`ifdef WVB_RD_ARB_TIMEOUT_EN
                else if (expire) begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    sel_d     = '0;
                    busy_d    = 1'b0;
                    last_d    = sel_q;
                    tmo_err_d = 1'b1;
                    wdog_d    = '0;
                end
`endif
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= P_SEL_WIDTH'(P_N_CHAN - 1);
            evts_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            evts_q  <= evts_d;
        end
    end

`ifdef WVB_RD_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wdog_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign bus.tmo_err = tmo_err_q;
`else
    logic unused_tmo_max;
    assign unused_tmo_max = ^bus.tmo_max;
    assign bus.tmo_err    = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.chan_sel = sel_q;
    assign bus.rd_start = start_q;
    assign bus.busy     = busy_q;
    assign bus.n_evts   = evts_q;

endmodule

// File: tb/tb_wvb_rd_arb.sv
// Directed, table-driven bench for wvb_rd_arb; timeout checks follow WVB_RD_ARB_TIMEOUT_EN.
module tb_wvb_rd_arb;
    import wvb_rd_arb_pkg::*;

    logic clk;
    logic i_rst;

    wvb_rd_arb_if bus ();

    wvb_rd_arb #(
        .P_N_CHAN    (24),
        .P_SEL_WIDTH (5),
        .P_TMO_WIDTH (16)
    ) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] hdr;
        logic [23:0] en;
        int unsigned ch;
        int unsigned dly;
    } vec_t;

    vec_t        vecs [10];
    int unsigned n_err;
    int unsigned n_checks;
    int unsigned exp_evts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start();
        int unsigned n;
        n = 0;
        while (bus.rd_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.rd_start !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL start_timeout: got no rd_start expected rd_start within 20 cycles");
        end
    endtask

    task automatic check_grant(input string name, input int unsigned ch);
        logic [23:0] one;
        one = 24'd1;
        chk({name, "_grant"}, 32'(bus.grant), 32'(one << ch));
        chk({name, "_sel"}, 32'(bus.chan_sel), ch);
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_read(input string name);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        exp_evts++;
        chk({name, "_gap_grant"}, 32'(bus.grant), 32'd0);
        chk({name, "_gap_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_gap_sel"}, 32'(bus.chan_sel), 32'd0);
        chk({name, "_n_evts"}, bus.n_evts, exp_evts);
    endtask

    task automatic do_read(input string name, input logic [23:0] hdr, input logic [23:0] en,
                           input int unsigned ch, input int unsigned dly);
        bus.hdr_rdy = hdr;
        bus.chan_en = en;
        wait_start();
        check_grant(name, ch);
        for (int unsigned k = 0; k < dly; k++) begin
            @(negedge clk);
            chk({name, "_start_pulse"}, 32'(bus.rd_start), 32'd0);
        end
        finish_read(name);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_sel", 32'(bus.chan_sel), 32'd0);
        chk("rst_start", 32'(bus.rd_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tmo_err", 32'(bus.tmo_err), 32'd0);
        chk("rst_n_evts", bus.n_evts, 32'd0);
        i_rst    = 1'b0;
        exp_evts = 0;
    endtask

    initial begin
        int unsigned cnt;
        int unsigned seen;
        n_err    = 0;
        n_checks = 0;
        exp_evts = 0;

        vecs[0] = '{24'h000005, 24'hFFFFFF, 0, 1};
        vecs[1] = '{24'h000005, 24'hFFFFFF, 2, 2};
        vecs[2] = '{24'h000005, 24'hFFFFFF, 0, 1};
        vecs[3] = '{24'h800001, 24'hFFFFFF, 23, 3};
        vecs[4] = '{24'h800001, 24'hFFFFFF, 0, 1};
        vecs[5] = '{24'h000003, 24'hFFFFFE, 1, 4};
        vecs[6] = '{24'h000003, 24'hFFFFFE, 1, 1};
        vecs[7] = '{24'h000100, 24'hFFFFFF, 8, 5};
        vecs[8] = '{24'h000081, 24'hFFFFFF, 0, 2};
        vecs[9] = '{24'h000081, 24'hFFFFFF, 7, 1};

        i_rst       = 1'b1;
        bus.hdr_rdy = '0;
        bus.chan_en = '1;
        bus.pause   = 1'b0;
        bus.rd_done = 1'b0;
        bus.tmo_max = '0;
        @(negedge clk);
        do_reset();

        for (int unsigned v = 0; v < 10; v++) begin
            do_read($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].en, vecs[v].ch, vecs[v].dly);
        end
        bus.hdr_rdy = '0;

        // pause in idle blocks grants; stray rd_done in idle is ignored
        bus.pause   = 1'b1;
        bus.hdr_rdy = 24'h000001;
        seen = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rd_start === 1'b1 || bus.busy === 1'b1) seen++;
            bus.rd_done = (k == 2);
        end
        bus.rd_done = 1'b0;
        chk("pause_no_grant", seen, 32'd0);
        @(negedge clk);
        chk("idle_done_ignored", bus.n_evts, exp_evts);
        bus.pause = 1'b0;
        wait_start();
        check_grant("unpause", 0);

        // rd_done alongside rd_start is ignored; grant holds while inputs change in S_WAIT
        bus.rd_done = 1'b1;
        bus.pause   = 1'b1;
        bus.hdr_rdy = '0;
        bus.chan_en = '0;
        @(negedge clk);
        bus.rd_done = 1'b0;
        @(negedge clk);
        check_grant("wait_hold", 0);
        chk("start_done_ignored", bus.n_evts, exp_evts);
        finish_read("pause_wait");
        bus.hdr_rdy = 24'h000001;
        bus.chan_en = '1;
        seen = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rd_start === 1'b1) seen++;
        end
        chk("pause_after_gap", seen, 32'd0);
        bus.pause   = 1'b0;
        bus.hdr_rdy = '0;
        @(negedge clk);

        // single eligible channel: rd_start period equals readout length plus 2
        bus.hdr_rdy = 24'h000010;
        wait_start();
        check_grant("b2b_first", 4);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt++;
        end
        bus.rd_done = 1'b1;
        @(negedge clk);
        cnt++;
        bus.rd_done = 1'b0;
        exp_evts++;
        while (bus.rd_start !== 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_period", cnt, 32'd6);
        check_grant("b2b_second", 4);
        bus.hdr_rdy = '0;
        @(negedge clk);
        finish_read("b2b_second");

        // reset mid-readout on channel 7
        bus.hdr_rdy = 24'h000080;
        wait_start();
        check_grant("rst_mid", 7);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_grant", 32'(bus.grant), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_start", 32'(bus.rd_start), 32'd0);
        chk("rst_mid_n_evts", bus.n_evts, 32'd0);
        i_rst    = 1'b0;
        exp_evts = 0;
        do_read("post_rst", 24'h000081, 24'hFFFFFF, 0, 1);

        // full sweep: two passes over every channel in order
        do_reset();
        for (int unsigned r = 0; r < 48; r++) begin
            do_read($sformatf("sweep%0d", r), 24'hFFFFFF, 24'hFFFFFF, r % 24, 1);
        end
        chk("sweep_n_evts", bus.n_evts, 32'd48);
        bus.hdr_rdy = '0;
        @(negedge clk);

`ifdef WVB_RD_ARB_TIMEOUT_EN
        bus.tmo_max = 16'd100;
        bus.hdr_rdy = 24'h000001;
        wait_start();
        check_grant("tmo", 0);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo_cycles", cnt, 32'd101);
        chk("tmo_err_set", 32'(bus.tmo_err), 32'd1);
        chk("tmo_n_evts", bus.n_evts, exp_evts);
`else
        bus.tmo_max = 16'd100;
        bus.hdr_rdy = 24'h000001;
        wait_start();
        check_grant("no_tmo", 0);
        repeat (120) @(negedge clk);
        chk("no_tmo_busy", 32'(bus.busy), 32'd1);
        chk("no_tmo_err", 32'(bus.tmo_err), 32'd0);
        finish_read("no_tmo");
`endif
        do_read("after_wait", 24'h000003, 24'hFFFFFF, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
